// File: rtl/inst_prefetch_unit_pkg.sv
// Shared defaults and helpers for the instruction prefetch unit.
package inst_prefetch_unit_pkg;

   localparam int unsigned PcLength      = 32;
   localparam int unsigned InstLength    = 32;
   localparam int unsigned PrefetchDepth = 4;
   localparam int unsigned MemLatency    = 0;
   localparam int unsigned PcStep        = 4;

   // Bits needed for a counter spanning 0..n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/inst_prefetch_unit_if.sv
// Core/ROM-facing bus of the prefetch unit; master is the prefetch unit side.
interface inst_prefetch_unit_if
   import inst_prefetch_unit_pkg::*;
#(
   parameter int unsigned PC_WIDTH   = PcLength,
   parameter int unsigned INST_WIDTH = InstLength,
   parameter int unsigned OCC_WIDTH  = cnt_width(PrefetchDepth)
);

   logic                  romCe;
   logic [PC_WIDTH-1:0]   romAddr;
   logic [INST_WIDTH-1:0] romData;
   logic                  redirect;
   logic [PC_WIDTH-1:0]   redirectPc;
   logic                  instValid;
   logic [INST_WIDTH-1:0] inst;
   logic [PC_WIDTH-1:0]   instPc;
   logic                  instReady;
   logic [OCC_WIDTH-1:0]  occupancy;

   modport master (
      output romCe, romAddr, instValid, inst, instPc, occupancy,
      input  romData, redirect, redirectPc, instReady
   );

   modport slave (
      input  romCe, romAddr, instValid, inst, instPc, occupancy,
      output romData, redirect, redirectPc, instReady
   );

endinterface

// File: rtl/inst_prefetch_unit_fetch_fifo.sv
// Synchronous {pc, inst} FIFO with flush; the head output holds its last value when empty.
module fetch_fifo
   import inst_prefetch_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           push,
   input  logic [WIDTH-1:0]               wdata,
   input  logic                           pop,
   output logic [WIDTH-1:0]               rdata,
   output logic [cnt_width(DEPTH)-1:0]    count
);

   localparam int unsigned PtrWidth = (DEPTH < 2) ? 1 : $clog2(DEPTH);
   localparam int unsigned CntWidth = cnt_width(DEPTH);

   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [PtrWidth-1:0] wptr_q, rptr_q;
   logic [CntWidth-1:0] count_q;
   logic [WIDTH-1:0]    last_q;
   logic                do_push, do_pop;

   function automatic logic [PtrWidth-1:0] bump(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(DEPTH - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   assign do_push = push && !flush && (count_q != CntWidth'(DEPTH));
   assign do_pop  = pop && !flush && (count_q != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= bump(wptr_q);
         if (do_pop)  rptr_q <= bump(rptr_q);
         if (do_push && !do_pop)      count_q <= count_q + CntWidth'(1);
         else if (do_pop && !do_push) count_q <= count_q - CntWidth'(1);
      end
   end

   // Remember the visible head so the output does not change once drained or flushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= '0;
      end else if (count_q != '0) begin
         last_q <= mem_q[rptr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

   assign rdata = (count_q != '0) ? mem_q[rptr_q] : last_q;
   assign count = count_q;

endmodule

// File: rtl/inst_prefetch_unit.sv
// Sequential instruction prefetcher between the core and a fixed-latency instruction ROM.
module inst_prefetch_unit
   import inst_prefetch_unit_pkg::*;
#(
   parameter int unsigned         PC_WIDTH    = PcLength,
   parameter int unsigned         INST_WIDTH  = InstLength,
   parameter int unsigned         DEPTH       = PrefetchDepth,
   parameter int unsigned         MEM_LATENCY = MemLatency,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input logic                  clk,
   input logic                  rst,
   inst_prefetch_unit_if.master bus
);

   localparam int unsigned OccWidth = cnt_width(DEPTH);
   localparam int unsigned PipeLen  = (MEM_LATENCY == 0) ? 1 : MEM_LATENCY;
   localparam int unsigned SumWidth = OccWidth + 2;

   logic [PC_WIDTH-1:0]            fetch_pc_q, fetch_pc_d;
   logic [PipeLen-1:0]             pipe_vld_q;
   logic [PC_WIDTH-1:0]            pipe_pc_q [PipeLen];
   logic [2:0]                     inflight;
   logic [OccWidth-1:0]            occ;
   logic                           credit_ok, issue, push, pop;
   logic [PC_WIDTH-1:0]            push_pc;
   logic [PC_WIDTH+INST_WIDTH-1:0] head;

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < PipeLen; i++) begin
         inflight = inflight + 3'(pipe_vld_q[i]);
      end
   end

   // Credit counts reads already in flight so the FIFO can never overflow.
   assign credit_ok = (SumWidth'(occ) + SumWidth'(inflight)) < SumWidth'(DEPTH);
   assign issue     = !rst && !bus.redirect && credit_ok;

   assign bus.romCe   = issue;
   assign bus.romAddr = fetch_pc_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (bus.redirect) begin
         fetch_pc_d = {bus.redirectPc[PC_WIDTH-1:2], 2'b00};
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + PC_WIDTH'(PcStep);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
      end else begin
         fetch_pc_q <= fetch_pc_d;
      end
   end

   if (MEM_LATENCY == 0) begin : g_comb_rom
      assign pipe_vld_q   = '0;
      assign pipe_pc_q[0] = '0;
      assign push         = issue;
      assign push_pc      = fetch_pc_q;
   end else begin : g_pipe_rom
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            pipe_vld_q <= '0;
         end else if (bus.redirect) begin
            pipe_vld_q <= '0;
         end else begin
            pipe_vld_q[0] <= issue;
            for (int unsigned i = 1; i < PipeLen; i++) begin
               pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
         end
      end

      always_ff @(posedge clk) begin
         pipe_pc_q[0] <= fetch_pc_q;
         for (int unsigned i = 1; i < PipeLen; i++) begin
            pipe_pc_q[i] <= pipe_pc_q[i-1];
         end
      end

      assign push    = pipe_vld_q[PipeLen-1] && !bus.redirect;
      assign push_pc = pipe_pc_q[PipeLen-1];
   end

   assign bus.instValid = (occ != '0) && !bus.redirect;
   assign pop           = bus.instValid && bus.instReady;

   fetch_fifo #(
      .WIDTH (PC_WIDTH + INST_WIDTH),
      .DEPTH (DEPTH)
   ) u_fetch_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.redirect),
      .push  (push),
      .wdata ({push_pc, bus.romData}),
      .pop   (pop),
      .rdata (head),
      .count (occ)
   );

   assign bus.instPc    = head[INST_WIDTH +: PC_WIDTH];
   assign bus.inst      = head[INST_WIDTH-1:0];
   assign bus.occupancy = occ;

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Directed bench: four prefetch unit configurations, each fed by a ROM model with word = addr ^ A5A5_0000.
module tb_inst_prefetch_unit;

   localparam int NumDut = 4;
   localparam logic [31:0] Salt = 32'hA5A5_0000;

   function automatic int unsigned cfg_lat(input int g);
      case (g)
         0:       return 0;
         1:       return 2;
         2:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic int unsigned cfg_dep(input int g);
      return (g == 2) ? 3 : 4;
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NumDut-1:0]       rst = '1;
   logic [NumDut-1:0]       redirect = '0;
   logic [NumDut-1:0][31:0] redirect_pc = '0;
   logic [NumDut-1:0]       inst_ready = '0;
   logic [NumDut-1:0]       o_ce;
   logic [NumDut-1:0]       o_valid;
   logic [NumDut-1:0][31:0] o_addr;
   logic [NumDut-1:0][31:0] o_inst;
   logic [NumDut-1:0][31:0] o_pc;
   logic [NumDut-1:0][31:0] o_occ;

   for (genvar g = 0; g < NumDut; g++) begin : g_dut
      localparam int unsigned Lat  = cfg_lat(g);
      localparam int unsigned Dep  = cfg_dep(g);
      localparam int unsigned OccW = $clog2(Dep + 1);

      inst_prefetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32), .OCC_WIDTH(OccW)) bus ();

      inst_prefetch_unit #(
         .PC_WIDTH    (32),
         .INST_WIDTH  (32),
         .DEPTH       (Dep),
         .MEM_LATENCY (Lat),
         .RESET_PC    (32'h0)
      ) dut (
         .clk (clk),
         .rst (rst[g]),
         .bus (bus)
      );

      logic [31:0] addr_d [4];
      always_ff @(posedge clk) begin
         addr_d[0] <= bus.romAddr;
         for (int i = 1; i < 4; i++) addr_d[i] <= addr_d[i-1];
      end

      if (Lat == 0) begin : g_rom0
         assign bus.romData = bus.romAddr ^ Salt;
      end else begin : g_romn
         assign bus.romData = addr_d[Lat-1] ^ Salt;
      end

      assign bus.redirect   = redirect[g];
      assign bus.redirectPc = redirect_pc[g];
      assign bus.instReady  = inst_ready[g];
      assign o_ce[g]        = bus.romCe;
      assign o_valid[g]     = bus.instValid;
      assign o_addr[g]      = bus.romAddr;
      assign o_inst[g]      = bus.inst;
      assign o_pc[g]        = bus.instPc;
      assign o_occ[g]       = 32'(bus.occupancy);
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Holds rst across an edge, checks the reset outputs, and releases into cycle 0.
   task automatic reset_dut(input int g);
      rst[g]         = 1'b1;
      redirect[g]    = 1'b0;
      redirect_pc[g] = '0;
      inst_ready[g]  = 1'b0;
      cyc();
      @(negedge clk);
      chk($sformatf("d%0d rst ce", g), 32'(o_ce[g]), 32'd0);
      chk($sformatf("d%0d rst valid", g), 32'(o_valid[g]), 32'd0);
      chk($sformatf("d%0d rst occ", g), o_occ[g], 32'd0);
      chk($sformatf("d%0d rst inst", g), o_inst[g], 32'd0);
      chk($sformatf("d%0d rst pc", g), o_pc[g], 32'd0);
      cyc();
      rst[g] = 1'b0;
   endtask

   task automatic chk_head(input string name, input int g, input logic [31:0] pc);
      chk({name, " valid"}, 32'(o_valid[g]), 32'd1);
      chk({name, " pc"}, o_pc[g], pc);
      chk({name, " inst"}, o_inst[g], pc ^ Salt);
   endtask

   typedef struct {
      int          dut;
      bit          rst_first;
      bit          ready;
      bit          ce;
      logic [31:0] addr;
      bit          valid;
      logic [31:0] pc;
      int          occ;
   } vec_t;

   vec_t vecs[$];

   initial begin
      // Cold start, combinational ROM, depth 4, always ready.
      vecs.push_back('{0, 1, 1, 1, 32'h00, 0, 32'h00, 0});
      vecs.push_back('{0, 0, 1, 1, 32'h04, 1, 32'h00, 1});
      vecs.push_back('{0, 0, 1, 1, 32'h08, 1, 32'h04, 1});
      vecs.push_back('{0, 0, 1, 1, 32'h0C, 1, 32'h08, 1});
      vecs.push_back('{0, 0, 1, 1, 32'h10, 1, 32'h0C, 1});
      // Backpressure, latency 2, depth 4: fill to 4, stall, then drain.
      vecs.push_back('{1, 1, 0, 1, 32'h00, 0, 32'h00, 0});
      vecs.push_back('{1, 0, 0, 1, 32'h04, 0, 32'h00, 0});
      vecs.push_back('{1, 0, 0, 1, 32'h08, 0, 32'h00, 0});
      vecs.push_back('{1, 0, 0, 1, 32'h0C, 1, 32'h00, 1});
      vecs.push_back('{1, 0, 0, 0, 32'h10, 1, 32'h00, 2});
      vecs.push_back('{1, 0, 0, 0, 32'h10, 1, 32'h00, 3});
      vecs.push_back('{1, 0, 0, 0, 32'h10, 1, 32'h00, 4});
      vecs.push_back('{1, 0, 0, 0, 32'h10, 1, 32'h00, 4});
      vecs.push_back('{1, 0, 1, 0, 32'h10, 1, 32'h00, 4});
      vecs.push_back('{1, 0, 1, 1, 32'h10, 1, 32'h04, 3});
      vecs.push_back('{1, 0, 1, 1, 32'h14, 1, 32'h08, 2});
      vecs.push_back('{1, 0, 1, 1, 32'h18, 1, 32'h0C, 1});
      vecs.push_back('{1, 0, 1, 1, 32'h1C, 1, 32'h10, 1});

      foreach (vecs[i]) begin
         int g;
         g = vecs[i].dut;
         if (vecs[i].rst_first) reset_dut(g);
         inst_ready[g] = vecs[i].ready;
         @(negedge clk);
         chk($sformatf("v%0d ce", i), 32'(o_ce[g]), 32'(vecs[i].ce));
         chk($sformatf("v%0d addr", i), o_addr[g], vecs[i].addr);
         chk($sformatf("v%0d valid", i), 32'(o_valid[g]), 32'(vecs[i].valid));
         chk($sformatf("v%0d occ", i), o_occ[g], 32'(vecs[i].occ));
         if (vecs[i].valid) begin
            chk($sformatf("v%0d pc", i), o_pc[g], vecs[i].pc);
            chk($sformatf("v%0d inst", i), o_inst[g], vecs[i].pc ^ Salt);
         end
         cyc();
      end

      // Redirect with two reads in flight and two entries buffered (latency 2).
      begin
         int waited;
         reset_dut(1);
         repeat (4) cyc();
         redirect[1]    = 1'b1;
         redirect_pc[1] = 32'h0000_0103;
         @(negedge clk);
         chk("redir occ before", o_occ[1], 32'd2);
         chk("redir valid", 32'(o_valid[1]), 32'd0);
         chk("redir ce", 32'(o_ce[1]), 32'd0);
         cyc();
         redirect[1]   = 1'b0;
         inst_ready[1] = 1'b1;
         @(negedge clk);
         chk("redir occ after", o_occ[1], 32'd0);
         chk("redir addr", o_addr[1], 32'h100);
         chk("redir ce after", 32'(o_ce[1]), 32'd1);
         waited = 0;
         while (!o_valid[1] && waited < 8) begin
            cyc();
            @(negedge clk);
            waited++;
         end
         chk("redir latency", 32'(waited), 32'd3);
         chk_head("redir first", 1, 32'h100);
         cyc();
         @(negedge clk);
         chk_head("redir second", 1, 32'h104);
         cyc();
         @(negedge clk);
         chk_head("redir third", 1, 32'h108);
      end

      // Simultaneous push and pop, latency 1, depth 3.
      reset_dut(2);
      inst_ready[2] = 1'b1;
      repeat (2) cyc();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("pp%0d occ", c), o_occ[2], 32'd1);
         chk_head($sformatf("pp%0d", c), 2, 32'(4 * c));
         cyc();
      end

      // Address wrap-around after a redirect near the top of memory.
      reset_dut(0);
      redirect[0]    = 1'b1;
      redirect_pc[0] = 32'hFFFF_FFF8;
      inst_ready[0]  = 1'b1;
      @(negedge clk);
      chk("wrap redir valid", 32'(o_valid[0]), 32'd0);
      cyc();
      redirect[0] = 1'b0;
      @(negedge clk);
      chk("wrap addr", o_addr[0], 32'hFFFF_FFF8);
      chk("wrap ce", 32'(o_ce[0]), 32'd1);
      cyc();
      begin
         logic [31:0] exp_pc [4];
         exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_head($sformatf("wrap%0d", k), 0, exp_pc[k]);
            cyc();
         end
      end

      // Asynchronous reset with a full FIFO, latency 3.
      reset_dut(3);
      redirect[3]    = 1'b1;
      redirect_pc[3] = 32'h200;
      cyc();
      redirect[3] = 1'b0;
      repeat (12) cyc();
      @(negedge clk);
      chk("mid full occ", o_occ[3], 32'd4);
      chk("mid full ce", 32'(o_ce[3]), 32'd0);
      chk_head("mid full head", 3, 32'h200);
      rst[3] = 1'b1;
      #1;
      chk("mid async occ", o_occ[3], 32'd0);
      chk("mid async valid", 32'(o_valid[3]), 32'd0);
      chk("mid async inst", o_inst[3], 32'd0);
      chk("mid async pc", o_pc[3], 32'd0);
      chk("mid async ce", 32'(o_ce[3]), 32'd0);
      chk("mid async addr", o_addr[3], 32'd0);
      cyc();
      @(negedge clk);
      chk("mid held occ", o_occ[3], 32'd0);
      chk("mid held valid", 32'(o_valid[3]), 32'd0);
      cyc();
      rst[3]        = 1'b0;
      inst_ready[3] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("post addr", o_addr[3], 32'd0);
            chk("post ce", 32'(o_ce[3]), 32'd1);
         end
         if (c < 4) chk($sformatf("post%0d valid", c), 32'(o_valid[3]), 32'd0);
         else chk_head($sformatf("post%0d", c), 3, 32'(4 * (c - 4)));
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/inst_prefetch_unit.md
Name: inst_prefetch_unit

Overview:
- Parametrised successor to the direct core-to-InstMem fetch path: decouples the MIPS core from instruction memory.
- Issues sequential fetch addresses to an instruction ROM with configurable fixed read latency.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry FIFO. The core pops them with a valid/ready handshake.
- Supports branch redirect with flush of both the buffer and in-flight reads. Sits between the MIPS core and InstMem in the SOC top.

Parameters:
- PC_WIDTH, 32, fetch address width (matches `PC_LENGTH).
- INST_WIDTH, 32, instruction width (matches `INST_LENGTH).
- DEPTH, 4, FIFO entries; legal 2..16.
- MEM_LATENCY, 0, ROM read latency in cycles; legal 0..3. 0 = combinational ROM (current InstMem).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- romCe  out  1  ROM read enable; one read per cycle it is high.
- romAddr  out  PC_WIDTH  ROM read address (= fetchPc).
- romData  in  INST_WIDTH  ROM read data.
- redirect  in  1  core branch/jump redirect request.
- redirectPc  in  PC_WIDTH  new fetch address, valid with redirect.
- instValid  out  1  head instruction available.
- inst  out  INST_WIDTH  head instruction.
- instPc  out  PC_WIDTH  PC of head instruction.
- instReady  in  1  core accepts head.
- occupancy  out  $clog2(DEPTH+1)  current FIFO entry count.

Behaviour:
- Reset (async, rst=1), held for the whole assertion:
  - fetchPc=RESET_PC; FIFO empty; in-flight pipeline cleared.
  - romCe=0, instValid=0, inst=0, instPc=0, occupancy=0.
- Internal state:
  - fetchPc register.
  - Response pipeline of MEM_LATENCY stages, each holding {valid, pc}.
  - FIFO of {pc, inst}.
  - inflight = number of valid pipeline stages.
- Issue rule:
  - romCe = !rst && !redirect && (occupancy + inflight < DEPTH). The credit check uses registered values only; a same-cycle pop does not add credit.
  - romAddr = fetchPc.
  - On an issue cycle, fetchPc <= fetchPc + 4, modulo 2^PC_WIDTH, so 0xFFFF_FFFC wraps to 0.
- Latency:
  - Read issued in cycle t: romData is valid in cycle t+MEM_LATENCY.
  - {pc, romData} is written to the FIFO at the edge ending cycle t+MEM_LATENCY.
  - Earliest instValid is cycle t+MEM_LATENCY+1.
  - Sustained 1 inst/cycle requires DEPTH >= MEM_LATENCY+2.
- Pop:
  - instValid = (occupancy != 0) && !redirect.
  - A pop occurs when instValid && instReady; the head is removed at the clock edge.
  - inst and instPc show the head entry, and hold their last value when the FIFO is empty.
- Simultaneous push and pop: both happen and occupancy is unchanged. Overflow is impossible by the credit rule.
- Redirect (has priority over everything except reset), in the redirect cycle:
  - no issue, no pop, no push.
  - At the edge: FIFO emptied, all pipeline valid bits cleared (stale responses discarded), fetchPc <= redirectPc.
  - First new issue is the next cycle, at redirectPc.
  - Back-to-back redirects: the last one wins.
- redirectPc low two bits are forced to 0.
- occupancy counts FIFO entries only, not in-flight reads.
- Reset mid-operation: all state is discarded immediately; no partial entries survive. Fetch resumes at RESET_PC on the first edge after rst deasserts.

Decomposition:
- Shared defines file (existing macro header) adds `PREFETCH_DEPTH and `MEM_LATENCY defaults alongside `PC_LENGTH / `INST_LENGTH.
- One sub-module: fetch_fifo.
  - Synchronous FIFO, WIDTH = PC_WIDTH+INST_WIDTH, DEPTH entries.
  - Read/write pointers with wrap, count, flush input, async reset.
- The issue/credit logic and latency pipeline stay in inst_prefetch_unit.

Test Plan:
- Reset/cold start, MEM_LATENCY=0, DEPTH=4, instReady=1, ROM word at addr A = A^32'hA5A5_0000 -> cycle 0 after rst: romAddr=0x0. Cycle 1: instValid=1, instPc=0x0. Thereafter instPc 0x4, 0x8, … one per cycle, inst matching.
- Backpressure, MEM_LATENCY=2, DEPTH=4, instReady=0 -> exactly 4 reads issued (0x0..0xC). romCe stays 0 once occupancy=4, which is steady state. Raise instReady -> pops 0x0,0x4,0x8,0xC, then 0x10 follows; no drops, no duplicates.
- Redirect with in-flight reads, MEM_LATENCY=2:
  - Stimulus: pulse redirect with redirectPc=0x100 while 2 reads are in flight and occupancy=2.
  - Response: in that cycle instValid=0; next cycle occupancy=0, romAddr=0x100.
  - The stale responses for the old addresses never appear; the first popped instPc is 0x100.
- Simultaneous push/pop, MEM_LATENCY=1, DEPTH=3 -> occupancy holds constant across cycles with both push and pop. Sequence is continuous.
- Wrap-around: redirectPc=0xFFFF_FFF8 -> popped instPc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Reset mid-stream, MEM_LATENCY=3, FIFO full -> on rst assertion (asynchronous, between edges), outputs go to 0 immediately. After release, the first romAddr is RESET_PC and no pre-reset instruction is ever presented.
